// File: rtl/debounce_multi.sv
// N-channel symmetric push-button debouncer: 2-flop synchroniser per channel,
// debounced level, 1-cycle press/release pulses and a long-press pulse.
module debounce_multi #(
    parameter int N        = 4,
    parameter int CNT_MAX  = 250000,
    parameter int LONG_MAX = 25000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] button,
    output logic [N-1:0] btn_state,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] long_press
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int HW = $clog2(LONG_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MAX - 1);

    logic [N-1:0] sync1_reg;
    logic [N-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            logic [CW-1:0] cnt_reg, cnt_next;
            logic [HW-1:0] hold_reg, hold_next;
            logic          state_reg, state_next;
            logic          press_reg, press_next;
            logic          release_reg, release_next;
            logic          long_reg, long_next;

            always_comb begin
                cnt_next     = '0;
                state_next   = state_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                hold_next    = '0;
                long_next    = 1'b0;

                // Any sample agreeing with the current level restarts the run.
                if (sync2_reg[gi] != state_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next   = sync2_reg[gi];
                        press_next   = sync2_reg[gi];
                        release_next = ~sync2_reg[gi];
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end

                // Hold saturates at LONG_MAX so the long pulse fires once per press.
                if (state_reg) begin
                    hold_next = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + HW'(1);
                    long_next = (hold_reg == HOLD_LAST);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg     <= '0;
                    hold_reg    <= '0;
                    state_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    long_reg    <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    hold_reg    <= hold_next;
                    state_reg   <= state_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                    long_reg    <= long_next;
                end
            end

            assign btn_state[gi]   = state_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
            assign long_press[gi]  = long_reg;
        end
    endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random bouncing,
// compared every cycle against a sample-window reference model.
module tb_debounce_multi;

    localparam int N        = 4;
    localparam int CNT_MAX  = 4;
    localparam int LONG_MAX = 10;

    logic         clk;
    logic         rst;
    logic [N-1:0] button;
    logic [N-1:0] btn_state, btn_press, btn_release, long_press;
    logic [4*N-1:0] obs;

    debounce_multi #(.N(N), .CNT_MAX(CNT_MAX), .LONG_MAX(LONG_MAX)) dut (
        .clk(clk), .rst(rst), .button(button),
        .btn_state(btn_state), .btn_press(btn_press),
        .btn_release(btn_release), .long_press(long_press)
    );

    assign obs = {btn_state, btn_press, btn_release, long_press};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int edge_no = 0;

    // Reference model: a level flips once the last CNT_MAX synchronised samples
    // all disagree with it; long press is a fixed distance from the press edge.
    bit [N-1:0] m_d1, m_d2, m_state;
    bit [N-1:0] e_press, e_release, e_long;
    bit         win [N][CNT_MAX];
    int         press_t [N];
    logic [4*N-1:0] exp_v;

    task automatic model_edge(input logic [N-1:0] b, input logic r);
        bit s2, all_diff, pre;
        if (!r) begin
            m_d1 = '0; m_d2 = '0; m_state = '0;
            e_press = '0; e_release = '0; e_long = '0;
            for (int i = 0; i < N; i++)
                for (int k = 0; k < CNT_MAX; k++) win[i][k] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                s2 = m_d2[i];
                for (int k = CNT_MAX - 1; k > 0; k--) win[i][k] = win[i][k-1];
                win[i][0] = s2;
                all_diff = 1'b1;
                for (int k = 0; k < CNT_MAX; k++)
                    if (win[i][k] == m_state[i]) all_diff = 1'b0;
                pre = m_state[i];
                e_long[i]    = pre && (edge_no - press_t[i] == LONG_MAX);
                e_press[i]   = all_diff && !pre;
                e_release[i] = all_diff && pre;
                if (all_diff) begin
                    m_state[i] = !pre;
                    if (!pre) press_t[i] = edge_no;
                end
            end
            m_d2 = m_d1;
            m_d1 = b;
        end
        exp_v = {m_state, e_press, e_release, e_long};
    endtask

    task automatic tick();
        logic [N-1:0] b;
        logic r;
        b = button;
        r = rst;
        @(posedge clk);
        edge_no++;
        model_edge(b, r);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        button = 4'b1011;
        repeat (3) begin
            tick();
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL reset edge %0d: got %h required 0000", edge_no, obs);
            end
        end
        button = '0;
        rst = 1'b1;
        repeat (8) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_idle edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
        end
    endtask

    task automatic test_press_release();
        int k, press_at, rel_at, n_press, n_rel, n_long;
        bit other;
        press_at = -1; rel_at = -1; n_press = 0; n_rel = 0; n_long = 0; other = 0;
        button = 4'b0001;
        k = edge_no + 1;
        repeat (24) begin
            tick();
            if (edge_no == k + 5) button = 4'b0000;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL press_release edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
            if (btn_press[0]) begin n_press++; press_at = edge_no; end
            if (btn_release[0]) begin n_rel++; rel_at = edge_no; end
            if (long_press[0]) n_long++;
            if (btn_state[3:1] != 0) other = 1;
        end
        vectors++;
        if (press_at != k + 5 || n_press != 1) begin
            miscompares++;
            $display("FAIL press_latency: got edge %0d (count %0d) required edge %0d (count 1)", press_at, n_press, k + 5);
        end
        vectors++;
        if (rel_at != k + 11 || n_rel != 1) begin
            miscompares++;
            $display("FAIL release_latency: got edge %0d (count %0d) required edge %0d (count 1)", rel_at, n_rel, k + 11);
        end
        vectors++;
        if (n_long != 0 || other) begin
            miscompares++;
            $display("FAIL short_hold: got long %0d other %0d required 0 0", n_long, other);
        end
    endtask

    task automatic test_bounce();
        int pattern [9] = '{3, 2, 3, 2, 3, 2, 3, 2, 0};
        int rise_at, press_at, n_press, early;
        bit lvl;
        rise_at = 0; press_at = -1; n_press = 0; early = 0; lvl = 1'b1;
        // 1x3,0x2,1x3,0x2,1x3,0x2,1x3,0x2 then final rise held
        for (int p = 0; p < 9; p++) begin
            button[1] = lvl;
            if (p == 8) rise_at = edge_no + 1;
            for (int c = 0; c < ((p == 8) ? 16 : pattern[p]); c++) begin
                tick();
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL bounce edge %0d: got %h required %h", edge_no, obs, exp_v);
                end
                if (btn_press[1]) begin n_press++; press_at = edge_no; end
                if (p < 8 && (btn_state[1] || btn_press[1])) early++;
            end
            lvl = !lvl;
        end
        vectors++;
        if (n_press != 1 || press_at != rise_at + 5 || early != 0) begin
            miscompares++;
            $display("FAIL bounce_press: got %0d presses at %0d, %0d early required 1 at %0d, 0 early", n_press, press_at, early, rise_at + 5);
        end
        button = '0;
        repeat (12) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL bounce_settle edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
        end
    endtask

    task automatic test_long_press();
        int press_at, long_at, n_long, n_rel;
        press_at = -1; long_at = -1; n_long = 0; n_rel = 0;
        button = 4'b0100;
        repeat (45) begin
            tick();
            if (edge_no - press_at == 29 && press_at > 0) button = 4'b0000;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL long edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
            if (btn_press[2]) press_at = edge_no;
            if (long_press[2]) begin n_long++; long_at = edge_no; end
            if (btn_release[2]) n_rel++;
        end
        vectors++;
        if (n_long != 1 || long_at != press_at + LONG_MAX || n_rel != 1) begin
            miscompares++;
            $display("FAIL long_timing: got %0d longs at %0d, %0d releases required 1 at %0d, 1 release", n_long, long_at, n_rel, press_at + LONG_MAX);
        end
    endtask

    task automatic test_simultaneous();
        int n_both, n_partial;
        n_both = 0; n_partial = 0;
        button = 4'b1001;
        repeat (20) begin
            tick();
            if (btn_state == 4'b1001) button = 4'b0000;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL simultaneous edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
            if (btn_press == 4'b1001) n_both++;
            else if (btn_press != 0) n_partial++;
        end
        vectors++;
        if (n_both != 1 || n_partial != 0) begin
            miscompares++;
            $display("FAIL simultaneous_press: got %0d joint %0d partial required 1 0", n_both, n_partial);
        end
    endtask

    task automatic test_reset_mid();
        int k2, rel_edge, press_at, stray;
        press_at = -1; stray = 0;
        button = 4'b0100;
        k2 = edge_no + 1;
        while (edge_no < k2 + 12) begin
            tick();
            if (edge_no == k2 + 7) button = 4'b0110;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_setup edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_mid edge %0d: got %h required 0000", edge_no, obs);
        end
        rst = 1'b1;
        rel_edge = edge_no;
        repeat (9) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_resume edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
            if (btn_press == 4'b0110 && press_at < 0) press_at = edge_no;
            if (long_press != 0 || btn_release != 0) stray++;
        end
        vectors++;
        if (press_at != rel_edge + 6 || stray != 0) begin
            miscompares++;
            $display("FAIL reset_repress: got edge %0d stray %0d required edge %0d stray 0", press_at, stray, rel_edge + 6);
        end
        button = '0;
        repeat (20) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_settle edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int run_left [N];
        for (int i = 0; i < N; i++) run_left[i] = $urandom_range(1, 14);
        repeat (800) begin
            for (int i = 0; i < N; i++) begin
                if (run_left[i] == 0) begin
                    button[i] = !button[i];
                    run_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 6);
                end else begin
                    run_left[i]--;
                end
            end
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random edge %0d: got %h required %h", edge_no, obs, exp_v);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        button = '0;
        test_reset();
        test_press_release();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
